// File: rtl/cnn_window_sched.sv
// Frame scheduler: tracks pixels written into the input RAM, steps the KxK
// window read pointer across the image and gates the conv core on data arrival.
module cnn_window_sched #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int KER   = 3,
  parameter int PPB   = 8,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rx_rdy,
  input  logic          win_ack,
  input  logic          frame_done,
  output logic [AW-1:0] addr_wr,
  output logic [AW-1:0] addr_rd,
  output logic          win_vld,
  output logic [4:0]    win_col,
  output logic [4:0]    win_row,
  output logic          win_last,
  output logic          busy,
  output logic          overrun
);

  localparam logic [AW-1:0] TOTAL   = AW'(IMG_W * IMG_H);
  localparam logic [AW:0]   TOTAL_X = (AW+1)'(IMG_W * IMG_H);
  localparam logic [AW-1:0] RD0     = AW'((KER - 1) * IMG_W + KER - 1);
  localparam logic [4:0]    COL_MAX = 5'(IMG_W - KER);
  localparam logic [4:0]    ROW_MAX = 5'(IMG_H - KER);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
  state_t state;

  logic [AW:0] wr_sum;

  // One bit wider so the saturation compare cannot wrap.
  assign wr_sum   = {1'b0, addr_wr} + (AW+1)'(PPB);
  assign win_vld  = (state == LOAD) && (addr_rd < addr_wr);
  assign win_last = (win_col == COL_MAX) && (win_row == ROW_MAX);
  assign busy     = (state != IDLE);

  // frame_done re-arms exactly like reset and outranks a same-cycle byte or ack.
  always_ff @(posedge clk) begin
    if (!rst_n || frame_done) begin
      state   <= IDLE;
      addr_wr <= '0;
      addr_rd <= RD0;
      win_col <= '0;
      win_row <= '0;
      overrun <= 1'b0;
    end else begin
      if (rx_rdy) begin
        if (addr_wr >= TOTAL)
          overrun <= 1'b1;
        else if (wr_sum > TOTAL_X)
          addr_wr <= TOTAL;
        else
          addr_wr <= wr_sum[AW-1:0];
        if (state == IDLE)
          state <= LOAD;
      end
      if (win_ack && win_vld) begin
        if (win_last) begin
          state <= DONE;
        end else if (win_col == COL_MAX) begin
          // Jump over the KER-1 pixels that cannot be a window's right edge.
          addr_rd <= addr_rd + AW'(KER);
          win_col <= '0;
          win_row <= win_row + 5'd1;
        end else begin
          addr_rd <= addr_rd + AW'(1);
          win_col <= win_col + 5'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_cnn_window_sched.sv
// Bench for cnn_window_sched: vector table, directed frame sequences and
// random traffic against a window-index reference model.
module tb_cnn_window_sched;

  localparam int IMG_W = 28, IMG_H = 28, KER = 3, PPB = 8, AW = 10;
  localparam int NW = IMG_W - KER + 1;
  localparam int NWIN = NW * (IMG_H - KER + 1);
  localparam int TOTAL = IMG_W * IMG_H;

  logic clk = 1'b0, rst_n = 1'b0;
  logic rx_rdy = 1'b0, win_ack = 1'b0, frame_done = 1'b0;
  logic [AW-1:0] addr_wr, addr_rd;
  logic win_vld, win_last, busy, overrun;
  logic [4:0] win_col, win_row;

  cnn_window_sched #(.IMG_W(IMG_W), .IMG_H(IMG_H), .KER(KER), .PPB(PPB), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .rx_rdy(rx_rdy), .win_ack(win_ack), .frame_done(frame_done),
    .addr_wr(addr_wr), .addr_rd(addr_rd), .win_vld(win_vld), .win_col(win_col),
    .win_row(win_row), .win_last(win_last), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  // Model: frame described by bytes received and linear window index.
  int m_n, m_k;
  bit m_load, m_done, m_ovr;

  function automatic int e_wr();  return (m_n * PPB > TOTAL) ? TOTAL : m_n * PPB; endfunction
  function automatic int e_col(); return m_k % NW; endfunction
  function automatic int e_row(); return m_k / NW; endfunction
  function automatic int e_rd();  return (e_row() + KER - 1) * IMG_W + e_col() + KER - 1; endfunction
  function automatic bit e_vld(); return m_load && (e_rd() < e_wr()); endfunction

  function automatic void model_reset();
    m_n = 0; m_k = 0; m_load = 0; m_done = 0; m_ovr = 0;
  endfunction

  function automatic void model_update(input bit rx, input bit ack, input bit fd);
    bit v;
    if (fd) begin model_reset(); return; end
    v = e_vld();
    if (rx) begin
      if (m_n * PPB >= TOTAL) m_ovr = 1; else m_n++;
      if (!m_load && !m_done) m_load = 1;
    end
    if (ack && v) begin
      if (m_k == NWIN - 1) begin m_done = 1; m_load = 0; end
      else m_k++;
    end
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("addr_wr", int'(addr_wr), e_wr());
    chk("addr_rd", int'(addr_rd), e_rd());
    chk("win_col", int'(win_col), e_col());
    chk("win_row", int'(win_row), e_row());
    chk("win_vld", int'(win_vld), int'(e_vld()));
    chk("win_last", int'(win_last), int'(m_k == NWIN - 1));
    chk("busy", int'(busy), int'(m_load || m_done));
    chk("overrun", int'(overrun), int'(m_ovr));
  endtask

  task automatic step(input bit rx, input bit ack, input bit fd);
    @(negedge clk);
    rx_rdy = rx; win_ack = ack; frame_done = fd;
    @(posedge clk);
    if (rst_n) model_update(rx, ack, fd);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(0, 0, 0);
    step(0, 0, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit rx, ack, fd;
    int wr, rd;
    bit vld, bsy;
  } vec_t;
  vec_t vt[12];

  initial begin
    vt[0] = '{0, 0, 0, 0, 58, 0, 0};
    for (int i = 1; i <= 7; i++) vt[i] = '{1, 0, 0, 8 * i, 58, 0, 1};
    vt[8]  = '{1, 0, 0, 64, 58, 1, 1};
    vt[9]  = '{0, 1, 0, 64, 59, 1, 1};
    vt[10] = '{1, 1, 0, 72, 60, 1, 1};
    vt[11] = '{1, 0, 1, 0, 58, 0, 0};

    // Reset then idle
    do_reset();
    for (int i = 0; i < 5; i++) step(0, 0, 0);
    chk("rst addr_wr", int'(addr_wr), 0);
    chk("rst addr_rd", int'(addr_rd), 'h03A);
    chk("rst win_vld", int'(win_vld), 0);
    chk("rst busy", int'(busy), 0);
    chk("rst overrun", int'(overrun), 0);
    chk("rst win_last", int'(win_last), 0);
    chk("idle ack ignored", int'(addr_rd), 'h03A);

    // Vector table
    for (int i = 0; i < 12; i++) begin
      step(vt[i].rx, vt[i].ack, vt[i].fd);
      chk($sformatf("vec%0d addr_wr", i), int'(addr_wr), vt[i].wr);
      chk($sformatf("vec%0d addr_rd", i), int'(addr_rd), vt[i].rd);
      chk($sformatf("vec%0d win_vld", i), int'(win_vld), int'(vt[i].vld));
      chk($sformatf("vec%0d busy", i), int'(busy), int'(vt[i].bsy));
    end

    // Full frame: 98 bytes then an ack every cycle
    do_reset();
    for (int i = 0; i < TOTAL / PPB; i++) step(1, 0, 0);
    chk("full addr_wr", int'(addr_wr), TOTAL);
    for (int a = 1; a <= NWIN; a++) begin
      step(0, 1, 0);
      check_model();
      if (a == 25) chk("row0 end addr_rd", int'(addr_rd), 83);
      if (a == 26) begin
        chk("row1 addr_rd", int'(addr_rd), 86);
        chk("row1 win_row", int'(win_row), 1);
        chk("row1 win_col", int'(win_col), 0);
      end
      if (a == NWIN - 1) begin
        chk("last win_last", int'(win_last), 1);
        chk("last addr_rd", int'(addr_rd), 783);
        chk("last win_vld", int'(win_vld), 1);
      end
    end
    chk("done win_vld", int'(win_vld), 0);
    chk("done busy", int'(busy), 1);
    chk("done addr_rd held", int'(addr_rd), 783);
    step(1, 0, 0);
    chk("ovr addr_wr", int'(addr_wr), TOTAL);
    chk("ovr flag", int'(overrun), 1);
    step(0, 1, 0);
    chk("done ack ignored", int'(addr_rd), 783);

    // Mid-frame frame_done with a colliding byte
    do_reset();
    for (int i = 0; i < TOTAL / PPB; i++) step(1, 0, 0);
    for (int a = 0; a < NW * 3 + 4; a++) step(0, 1, 0);
    chk("mid win_row", int'(win_row), 3);
    step(1, 0, 1);
    chk("fd addr_wr", int'(addr_wr), 0);
    chk("fd addr_rd", int'(addr_rd), 'h03A);
    chk("fd busy", int'(busy), 0);
    chk("fd overrun", int'(overrun), 0);
    check_model();

    // Read pointer catches write pointer
    do_reset();
    for (int i = 0; i < 8; i++) step(1, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 1, 0);
    chk("catch addr_rd", int'(addr_rd), 64);
    chk("catch win_vld", int'(win_vld), 0);
    step(0, 1, 0);
    step(0, 1, 0);
    chk("stall addr_rd", int'(addr_rd), 64);
    chk("stall win_col", int'(win_col), 6);
    step(1, 0, 0);
    chk("resume win_vld", int'(win_vld), 1);
    chk("resume addr_rd", int'(addr_rd), 64);
    step(0, 1, 0);
    chk("resume step", int'(addr_rd), 65);
    check_model();

    // Random traffic against the model
    do_reset();
    for (int c = 0; c < 9000; c++) begin
      bit rx, ack, fd;
      rx  = ($urandom % 3) == 0;
      ack = ($urandom % 4) != 0;
      fd  = m_done ? (($urandom % 25) == 0) : (($urandom % 3000) == 0);
      step(rx, ack, fd);
      check_model();
    end

    @(negedge clk);
    rx_rdy = 0; win_ack = 0; frame_done = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
